// File: rtl/cell_sweep_pkg.sv
// Shared types and constants for the cell multiplexer sweep engine.
// Holds the FSM state encoding, the MISR polynomial and the bus widths.
package cell_sweep_pkg;

  localparam int VEC_W  = 6;
  localparam int PAGE_W = 5;
  localparam int SIG_W  = 16;
  localparam int CAP_W  = 8;

  localparam logic [SIG_W-1:0] MISR_POLY = 16'h1021;
  localparam logic [VEC_W-1:0] VEC_LAST  = '1;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    CAPTURE,
    EMIT,
    DONE
  } state_e;

  function automatic logic [SIG_W-1:0] misr_step(
    input logic [SIG_W-1:0] s,
    input logic [CAP_W-1:0] d
  );
    return {s[SIG_W-2:0], 1'b0}
         ^ (s[SIG_W-1] ? MISR_POLY : '0)
         ^ {8'h00, d};
  endfunction

endpackage

// File: rtl/cell_sweep_if.sv
// Sweep engine bus: control, cell multiplexer drive/capture, signature out.
// The master side is the controller/cell model; the slave side is the engine.
interface cell_sweep_if;
  import cell_sweep_pkg::*;

  logic              start;
  logic              abort;
  logic [PAGE_W-1:0] page_first;
  logic [PAGE_W-1:0] page_last;
  logic [PAGE_W-1:0] drv_page;
  logic [VEC_W-1:0]  drv_in;
  logic [CAP_W-1:0]  cap_out;
  logic [SIG_W-1:0]  sig;
  logic [PAGE_W-1:0] sig_page;
  logic              sig_valid;
  logic              busy;
  logic              done;
  logic [SIG_W-1:0]  golden_sig;
  logic [5:0]        fail_cnt;

  modport master (
    output start, abort, page_first, page_last,
    output cap_out, golden_sig,
    input  drv_page, drv_in, sig, sig_page,
    input  sig_valid, busy, done, fail_cnt
  );

  modport slave (
    input  start, abort, page_first, page_last,
    input  cap_out, golden_sig,
    output drv_page, drv_in, sig, sig_page,
    output sig_valid, busy, done, fail_cnt
  );

endinterface

// File: rtl/cell_sweep_misr.sv
// 16-bit MISR accumulating captured cell responses.
// load takes priority over en so a reseed never mixes with a capture.
module cell_sweep_misr
  import cell_sweep_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SIG_W-1:0] seed,
  input  logic             load,
  input  logic             en,
  input  logic [CAP_W-1:0] data,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (load)
      sig_d = seed;
    else if (en)
      sig_d = misr_step(sig_q, data);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_q <= '0;
    else        sig_q <= sig_d;
  end

  assign sig = sig_q;

endmodule

// File: rtl/cell_sweep.sv
// Page-by-page cell sweep: drives all 64 vectors per page, signs responses.
// Optional golden compare is enabled with CELL_SWEEP_GOLDEN_EN.
module cell_sweep
  import cell_sweep_pkg::*;
#(
  parameter int               SETTLE_CYCLES = 2,
  parameter logic [SIG_W-1:0] SIG_SEED      = 16'hFFFF
) (
  input logic         clk,
  input logic         rst_n,
  cell_sweep_if.slave bus
);

  // With no settle time a vector goes straight to capture.
  localparam state_e ENTRY =
    (SETTLE_CYCLES == 0) ? CAPTURE : DRIVE;
  localparam logic [3:0] SETTLE_LAST =
    (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);

  state_e            state_q, state_d;
  logic [PAGE_W-1:0] last_q, last_d;
  logic [PAGE_W-1:0] page_q, page_d;
  logic [VEC_W-1:0]  vec_q, vec_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [SIG_W-1:0]  hold_q, hold_d;
  logic [PAGE_W-1:0] spage_q, spage_d;

  logic             misr_load;
  logic             misr_en;
  logic [SIG_W-1:0] misr_sig;
  logic             emit_ok;
  logic             go;

  assign go      = (state_q == IDLE) && bus.start
                && !bus.abort;
  assign emit_ok = (state_q == EMIT) && !bus.abort;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    page_d    = page_q;
    vec_d     = vec_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    spage_d   = spage_q;
    misr_load = 1'b0;
    misr_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (go) begin
          last_d    = bus.page_last;
          page_d    = bus.page_first;
          vec_d     = '0;
          cnt_d     = '0;
          misr_load = 1'b1;
          if (bus.page_first > bus.page_last)
            state_d = DONE;
          else
            state_d = ENTRY;
        end
      end
      DRIVE: begin
        if (bus.abort)
          state_d = IDLE;
        else if (cnt_q == SETTLE_LAST)
          state_d = CAPTURE;
        else
          cnt_d = cnt_q + 4'd1;
      end
      CAPTURE: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          misr_en = 1'b1;
          cnt_d   = '0;
          if (vec_q == VEC_LAST) begin
            state_d = EMIT;
          end else begin
            vec_d   = vec_q + 6'd1;
            state_d = ENTRY;
          end
        end
      end
      EMIT: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          hold_d  = misr_sig;
          spage_d = page_q;
          if (page_q == last_q) begin
            state_d = DONE;
          end else begin
            page_d    = page_q + 5'd1;
            vec_d     = '0;
            cnt_d     = '0;
            misr_load = 1'b1;
            state_d   = ENTRY;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= '0;
      page_q  <= '0;
      vec_q   <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
      spage_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      page_q  <= page_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      spage_q <= spage_d;
    end
  end

  cell_sweep_misr u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .seed  (SIG_SEED),
    .load  (misr_load),
    .en    (misr_en),
    .data  (bus.cap_out),
    .sig   (misr_sig)
  );

`ifdef CELL_SWEEP_GOLDEN_EN
  logic [5:0] fail_q, fail_d;

  always_comb begin
    fail_d = fail_q;
    if (go)
      fail_d = '0;
    else if (emit_ok && (misr_sig != bus.golden_sig)
             && (fail_q != 6'd63))
      fail_d = fail_q + 6'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fail_q <= '0;
    else        fail_q <= fail_d;
  end

  assign bus.fail_cnt = fail_q;
`else
  logic unused_golden;
  assign unused_golden = ^bus.golden_sig;
  assign bus.fail_cnt  = '0;
`endif

  assign bus.drv_page  = page_q;
  assign bus.drv_in    = vec_q;
  assign bus.busy      = (state_q == DRIVE)
                      || (state_q == CAPTURE)
                      || (state_q == EMIT);
  assign bus.done      = (state_q == DONE);
  assign bus.sig_valid = emit_ok;
  assign bus.sig       = emit_ok ? misr_sig : hold_q;
  assign bus.sig_page  = emit_ok ? page_q : spage_q;

endmodule

// File: tb/tb_cell_sweep.sv
// Scoreboard bench for cell_sweep: expected signatures queued at start,
// popped by a monitor on every sig_valid.
module tb_cell_sweep;

  localparam int S = 2;
  localparam int PAGE_CYC = 64 * (S + 1) + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cell_sweep_if bus ();

  cell_sweep #(
    .SETTLE_CYCLES (S),
    .SIG_SEED      (16'hFFFF)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.cap_out = 8'(bus.drv_in) + 8'(bus.drv_page);

  int checks = 0;
  int errors = 0;
  int nvalid = 0;
  int ndone  = 0;
  logic [20:0] exp_q[$];
  logic [20:0] e;

  function automatic logic [15:0] ref_sig(input int p);
    logic [15:0] s;
    logic [7:0]  d;
    s = 16'hFFFF;
    for (int v = 0; v < 64; v++) begin
      d = 8'(v + p);
      s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0)
        ^ {8'h00, d};
    end
    return s;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.sig_valid) begin
        nvalid++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_sig_valid: page %0d sig %0h",
                   bus.sig_page, bus.sig);
        end else begin
          e = exp_q.pop_front();
          if ({bus.sig_page, bus.sig} !== e) begin
            errors++;
            $display("FAIL sig: got p%0d %0h expected p%0d %0h",
                     bus.sig_page, bus.sig, e[20:16], e[15:0]);
          end
        end
      end
      if (bus.done) ndone++;
    end
  end

  task automatic pulse_start(input logic [4:0] f,
                             input logic [4:0] l);
    @(posedge clk); #1;
    bus.page_first = f;
    bus.page_last  = l;
    bus.start      = 1'b1;
    @(posedge clk); #1;
    bus.start      = 1'b0;
  endtask

  task automatic run(input logic [4:0] f,
                     input logic [4:0] l,
                     output int busy_n,
                     output int cyc,
                     output bit got);
    if (f <= l)
      for (int p = int'(f); p <= int'(l); p++)
        exp_q.push_back({5'(p), ref_sig(p)});
    pulse_start(f, l);
    busy_n = 0;
    cyc    = 0;
    got    = 1'b0;
    for (int i = 0; i < 20000 && !got; i++) begin
      @(negedge clk);
      cyc++;
      if (bus.busy) busy_n++;
      if (bus.done) got = 1'b1;
    end
    chk("done_seen", 32'(got), 32'd1);
    @(negedge clk);
    chk("done_one_cycle", 32'(bus.done), 32'd0);
  endtask

  int  bn, cy, v0, d0, nexp;
  bit  gd, found;

  initial begin
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.page_first = '0;
    bus.page_last  = '0;
    bus.golden_sig = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_drv_page", 32'(bus.drv_page), 0);
    chk("rst_sig", 32'(bus.sig), 0);
    chk("rst_outs", 32'({bus.busy, bus.done,
                         bus.sig_valid, bus.fail_cnt}), 0);
    rst_n = 1'b1;

    // single page, settle 2
    v0 = nvalid;
    run(5'd3, 5'd3, bn, cy, gd);
    chk("p3_busy_cycles", 32'(bn), 32'(PAGE_CYC));
    chk("p3_done_after_busy", 32'(cy), 32'(PAGE_CYC + 1));
    chk("p3_valid_count", 32'(nvalid - v0), 1);
    chk("p3_sig_hold", 32'(bus.sig), 32'(ref_sig(3)));

    // full range 0..31
    v0 = nvalid;
    run(5'd0, 5'd31, bn, cy, gd);
    chk("all_busy_cycles", 32'(bn), 32'(32 * PAGE_CYC));
    chk("all_valid_count", 32'(nvalid - v0), 32);
    chk("all_no_wrap", 32'(bus.drv_page), 31);
    chk("all_sig_page_hold", 32'(bus.sig_page), 31);

    // empty range
    v0 = nvalid;
    run(5'd9, 5'd4, bn, cy, gd);
    chk("empty_busy", 32'(bn), 0);
    chk("empty_done_next", 32'(cy), 1);
    chk("empty_valid", 32'(nvalid - v0), 0);

    // abort at vector 40 of page 2
    v0 = nvalid;
    d0 = ndone;
    pulse_start(5'd2, 5'd3);
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk);
      if (bus.drv_page == 5'd2 && bus.drv_in == 6'd40)
        found = 1'b1;
    end
    chk("abort_reach_vec40", 32'(found), 1);
    @(posedge clk); #1;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    @(negedge clk);
    chk("abort_idle", 32'(bus.busy), 0);
    repeat (10) @(negedge clk);
    chk("abort_no_done", 32'(ndone - d0), 0);
    chk("abort_no_valid", 32'(nvalid - v0), 0);
    run(5'd2, 5'd2, bn, cy, gd);
    chk("restart_valid", 32'(nvalid - v0), 1);

    // golden compare, golden_sig = 0
    bus.golden_sig = 16'h0000;
    nexp = 0;
`ifdef CELL_SWEEP_GOLDEN_EN
    for (int p = 0; p < 2; p++)
      if (ref_sig(p) != 16'h0) nexp++;
`endif
    run(5'd0, 5'd1, bn, cy, gd);
    chk("fail_cnt", 32'(bus.fail_cnt), 32'(nexp));

    // asynchronous reset mid-sweep
    pulse_start(5'd5, 5'd6);
    repeat (100) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("arst_drv_page", 32'(bus.drv_page), 0);
    chk("arst_drv_in", 32'(bus.drv_in), 0);
    chk("arst_sig", 32'({bus.sig, bus.sig_page}), 0);
    chk("arst_flags", 32'({bus.busy, bus.done,
                          bus.sig_valid, bus.fail_cnt}), 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    v0 = nvalid;
    d0 = ndone;
    repeat (500) @(negedge clk);
    chk("arst_no_pulse", 32'((nvalid - v0) + (ndone - d0)), 0);
    chk("arst_idle", 32'(bus.busy), 0);

    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/cell_sweep.md
CELL_SWEEP -- requirements
Module: cell_sweep

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, meaning the number of cycles each vector is held before capture; the legal range is 0..15.
REQ-002 SHALL have parameter SIG_SEED, default 16'hFFFF, meaning the per-page MISR seed.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1 bit: begin a sweep; sampled in IDLE only.
REQ-006 SHALL have port abort, input, 1 bit: terminate a sweep.
REQ-007 SHALL have ports page_first and page_last, inputs, 5 bits each: the inclusive page range, latched at start.
REQ-008 SHALL have port drv_page, output, 5 bits: page select driven to the cell multiplexer.
REQ-009 SHALL have port drv_in, output, 6 bits: input vector driven to the cell multiplexer.
REQ-010 SHALL have port cap_out, input, 8 bits: cell multiplexer response.
REQ-011 SHALL have port sig, output, 16 bits: the finished page signature.
REQ-012 SHALL have port sig_page, output, 5 bits: the page that sig belongs to.
REQ-013 SHALL have port sig_valid, output, 1 bit: one-cycle pulse qualifying sig and sig_page.
REQ-014 SHALL have port busy, output, 1 bit: high in every state except IDLE and DONE.
REQ-015 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-016 SHALL have port golden_sig, input, 16 bits: the expected signature for the current page.
REQ-017 SHALL have port fail_cnt, output, 6 bits: count of mismatching pages, saturating at 63.

Function
REQ-018 SHALL implement the states IDLE, DRIVE, CAPTURE, EMIT and DONE.
REQ-019 SHALL, in IDLE with start=1, latch the page range, set drv_page=page_first and drv_in=0, seed the MISR with SIG_SEED, clear fail_cnt, and enter DRIVE.
REQ-020 SHALL, in IDLE with start=1 and page_first>page_last, go directly to DONE with no sig_valid.
REQ-021 SHALL hold DRIVE for SETTLE_CYCLES cycles (0 means a single pass-through cycle is skipped) and then enter CAPTURE.
REQ-022 SHALL, in CAPTURE, sample cap_out and update the MISR as next = (sig<<1) ^ (sig[15] ? 16'h1021 : 0) ^ {8'h00, cap_out}.
REQ-023 SHALL, in CAPTURE with drv_in<63, increment drv_in and return to DRIVE.
REQ-024 SHALL, in CAPTURE with drv_in=63, enter EMIT.
REQ-025 SHALL, in EMIT, assert sig_valid for exactly one cycle with sig set to the final MISR value and sig_page set to drv_page.
REQ-026 SHALL, in EMIT, advance to the next page by reseeding the MISR, setting drv_in=0 and incrementing drv_page, unless drv_page=page_last, in which case it enters DONE.
REQ-027 SHALL spend exactly 64*(SETTLE_CYCLES+1)+1 cycles per page.
REQ-028 SHALL, in DONE, assert done for one cycle and then return to IDLE.
REQ-029 SHALL ignore start outside IDLE.
REQ-030 SHALL, on abort in any busy state, return to IDLE on the next edge without asserting done or sig_valid.
REQ-031 SHALL give abort priority over every other transition.
REQ-032 SHALL handle page_last=31 without drv_page wrap-around.
REQ-033 SHALL hold sig and sig_page stable between sig_valid pulses.

Reset
REQ-034 SHALL, on rst_n low, immediately force: state=IDLE; drv_page=0, drv_in=0, sig=0, sig_page=0; sig_valid=0, busy=0, done=0, fail_cnt=0.
REQ-035 SHALL, on reset mid-sweep, discard all progress; no pulse SHALL follow.

Configuration
REQ-036 SHALL, with CELL_SWEEP_GOLDEN_EN defined, compare sig with golden_sig in EMIT and increment fail_cnt (saturating) on mismatch.
REQ-037 SHALL, without CELL_SWEEP_GOLDEN_EN, ignore golden_sig and tie fail_cnt to 0.

Structure
REQ-038 SHALL place the state enum, the MISR polynomial constant 16'h1021 and the vector and page widths (6, 5) in package cell_sweep_pkg.
REQ-039 SHALL implement the MISR as sub-module cell_sweep_misr, with ports seed, load, en, data[7:0] and sig[15:0].

Verification
REQ-040 SHALL cover: SETTLE_CYCLES=2, page_first=page_last=3, start pulse -> busy high 193 cycles, one sig_valid with sig_page=3, done one cycle later.
REQ-041 SHALL cover: cap_out=drv_in[5:0]+page model, pages 0..31 -> 32 sig_valid pulses with sig_page 0..31 in order, each sig equal to the reference model MISR.
REQ-042 SHALL cover: page_first=9, page_last=4 -> done on the cycle after start, zero sig_valid, busy never high.
REQ-043 SHALL cover: abort at vector 40 of page 2 -> IDLE next cycle, no done, and a new start restarts from SIG_SEED.
REQ-044 SHALL cover: CELL_SWEEP_GOLDEN_EN defined, golden_sig=0 over pages 0..1 -> fail_cnt=2; without the macro -> fail_cnt=0.
REQ-045 SHALL cover: rst_n low mid-sweep -> all outputs at their reset values asynchronously, with no pulse after release.
